video_fifo_adapter: RTL and testbench

- Sits between the video pixel-domain read FIFO (32-bit words from the framebuffer DMA) and the video output stages (framebuffer mode, text mode).
- Repacks the 32-bit FIFO stream into consumer reads of either 16 bits (text-mode glyph/attribute entries) or 32 bits (framebuffer pixels), selected per read.
- Exposes the same empty/re/rdata/rsize interface that the video mode stages consume.
- Prefetches ahead so a consumer reading every cycle sees no bubbles while the FIFO is non-empty.

---
 rtl/video_fifo_adapter_pkg.sv | 19 +
 rtl/video_fifo_adapter_if.sv | 32 +++
 rtl/video_fifo_adapter.sv | 145 ++++++++++++++
 tb/tb_video_fifo_adapter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_fifo_adapter_pkg.sv
//------------------------------------------------------------------------------
// video_fifo_adapter_pkg : shared read-size type and staging geometry
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package video_fifo_adapter_pkg;

   typedef enum logic {
      RSIZE_16 = 1'b0,
      RSIZE_32 = 1'b1
   } rsize_e;

   localparam int HALFWORD_W  = 16;
   localparam int STAGE_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/video_fifo_adapter_if.sv
//------------------------------------------------------------------------------
// video_fifo_adapter_if : upstream FIFO side and consumer side of the adapter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface video_fifo_adapter_if;
   import video_fifo_adapter_pkg::*;

   logic        flush_i;
   logic        fifo_empty_i;
   logic [31:0] fifo_rdata_i;
   logic        fifo_re_o;
   logic        empty_o;
   logic        re_i;
   rsize_e      rsize_i;
   logic [31:0] rdata_o;

   // slave is the adapter; master is the FIFO/consumer environment
   modport slave (
      input  flush_i, fifo_empty_i, fifo_rdata_i, re_i, rsize_i,
      output fifo_re_o, empty_o, rdata_o
   );

   modport master (
      output flush_i, fifo_empty_i, fifo_rdata_i, re_i, rsize_i,
      input  fifo_re_o, empty_o, rdata_o
   );

endinterface

`default_nettype wire

// File: rtl/video_fifo_adapter.sv
//------------------------------------------------------------------------------
// video_fifo_adapter : repacks 32-bit FIFO words into 16/32-bit consumer reads
// Optional underrun statistics ports: VIDEO_FIFO_ADAPTER_STATS_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module video_fifo_adapter
   import video_fifo_adapter_pkg::*;
#(
   parameter int FIFO_RD_LATENCY = 1,
   parameter int LOW_HALF_FIRST  = 1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
   output logic [15:0]         underrun_cnt_o,
   output logic                underrun_o,
`endif
   video_fifo_adapter_if.slave bus
);

   logic [HALFWORD_W-1:0] stage      [STAGE_DEPTH];
   logic [HALFWORD_W-1:0] stage_next [STAGE_DEPTH];
   logic [2:0]            count;
   logic [2:0]            count_next;
   logic [2:0]            need;
   logic [2:0]            popn;
   logic [2:0]            remain;
   logic [2:0]            fill_level;
   logic                  empty;
   logic                  pop;
   logic                  fifo_re;
   logic                  arrive;
   logic                  inflight;
   logic [HALFWORD_W-1:0] first_half;
   logic [HALFWORD_W-1:0] second_half;

   assign need   = (bus.rsize_i == RSIZE_32) ? 3'd2 : 3'd1;
   assign empty  = (count < need);
   assign pop    = bus.re_i & ~empty & ~bus.flush_i;
   assign popn   = pop ? need : 3'd0;
   assign remain = count - popn;

   // Entries already requested count against room so the buffer can never overflow
   assign fill_level = remain + {1'b0, inflight, 1'b0};
   assign fifo_re    = rstn_i & ~bus.fifo_empty_i & ~bus.flush_i & (fill_level <= 3'd2);

   generate
      if (FIFO_RD_LATENCY == 0) begin : g_fwft
         assign arrive   = fifo_re;
         assign inflight = 1'b0;
      end else begin : g_registered
         logic inflight_q;

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               inflight_q <= 1'b0;
            end else begin
               inflight_q <= fifo_re;
            end
         end

         assign arrive   = inflight_q & ~bus.flush_i;
         assign inflight = inflight_q;
      end
   endgenerate

   assign first_half  = (LOW_HALF_FIRST != 0) ? bus.fifo_rdata_i[15:0]  : bus.fifo_rdata_i[31:16];
   assign second_half = (LOW_HALF_FIRST != 0) ? bus.fifo_rdata_i[31:16] : bus.fifo_rdata_i[15:0];

   // Shift survivors down, zero-fill vacated slots, then append the arriving word
   always_comb begin
      logic [2:0] src;
      logic [2:0] slot;
      src  = 3'd0;
      slot = 3'd0;
      for (int i = 0; i < STAGE_DEPTH; i++) begin
         stage_next[i] = '0;
      end
      for (int i = 0; i < STAGE_DEPTH; i++) begin
         src  = 3'(i) + popn;
         slot = 3'(i);
         if (src < count) begin
            stage_next[i] = stage[src[1:0]];
         end
         if (arrive && (slot == remain)) begin
            stage_next[i] = first_half;
         end
         if (arrive && (slot == remain + 3'd1)) begin
            stage_next[i] = second_half;
         end
      end
   end

   assign count_next = remain + (arrive ? 3'd2 : 3'd0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         count <= 3'd0;
         for (int i = 0; i < STAGE_DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else if (bus.flush_i) begin
         count <= 3'd0;
         for (int i = 0; i < STAGE_DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         count <= count_next;
         for (int i = 0; i < STAGE_DEPTH; i++) begin
            stage[i] <= stage_next[i];
         end
      end
   end

   a_count_bound : assert property (@(posedge clk_i) disable iff (!rstn_i)
                                    count_next <= 3'(STAGE_DEPTH));

   assign bus.fifo_re_o = fifo_re;
   assign bus.empty_o   = empty;
   assign bus.rdata_o   = (bus.rsize_i == RSIZE_32) ? {stage[1], stage[0]}
                                                    : {16'h0000, stage[0]};

`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
   logic underrun;

   assign underrun = bus.re_i & empty;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         underrun_cnt_o <= 16'h0000;
         underrun_o     <= 1'b0;
      end else begin
         underrun_o <= underrun;
         if (underrun && (underrun_cnt_o != 16'hFFFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 16'h0001;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_fifo_adapter.sv
//------------------------------------------------------------------------------
// tb_video_fifo_adapter : directed + random checks against a queue-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_fifo_adapter;
   import video_fifo_adapter_pkg::*;

   localparam int LAT = 1;

   logic clk;
   logic rstn;

   video_fifo_adapter_if bus ();

`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
   logic [15:0] underrun_cnt;
   logic        underrun;
`endif

   video_fifo_adapter #(
      .FIFO_RD_LATENCY (LAT),
      .LOW_HALF_FIRST  (1)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
      .underrun_cnt_o (underrun_cnt),
      .underrun_o     (underrun),
`endif
      .bus            (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] fifo_q [$];
   logic [15:0] stq    [$];
   logic [31:0] pend;
   bit          inflight_m;
   logic [15:0] exp_cnt;
   bit          prev_ev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      stq.delete();
      inflight_m = 1'b0;
      exp_cnt    = 16'h0000;
      prev_ev    = 1'b0;
   endtask

   // One clock of stimulus: drive, compare against model, advance model on the edge
   task automatic step(input bit re, input bit sz, input bit fl,
                       output logic [31:0] rd, output logic emp);
      int need;
      int popn;
      int lvl;
      bit exp_empty;
      bit exp_re;
      bit ev;
      bit arrive;
      logic [31:0] word;
      bus.re_i         = re;
      bus.rsize_i      = rsize_e'(sz);
      bus.flush_i      = fl;
      bus.fifo_empty_i = (fifo_q.size() == 0);
      if (LAT == 0) bus.fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
      else          bus.fifo_rdata_i = inflight_m ? pend : $urandom;
      #1;
      need      = sz ? 2 : 1;
      exp_empty = (stq.size() < need);
      popn      = (re && !exp_empty && !fl) ? need : 0;
      lvl       = int'(stq.size()) - popn + 2 * int'(inflight_m);
      exp_re    = (fifo_q.size() != 0) && !fl && (lvl <= 2);
      ev        = re && exp_empty;
      chk("empty_o", {31'd0, bus.empty_o}, {31'd0, exp_empty});
      chk("fifo_re_o", {31'd0, bus.fifo_re_o}, {31'd0, exp_re});
      if (!exp_empty) chk("rdata_o", bus.rdata_o, sz ? {stq[1], stq[0]} : {16'h0000, stq[0]});
`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
      chk("underrun_cnt_o", {16'd0, underrun_cnt}, {16'd0, exp_cnt});
      chk("underrun_o", {31'd0, underrun}, {31'd0, prev_ev});
`endif
      rd  = bus.rdata_o;
      emp = bus.empty_o;
      @(posedge clk);
      if (ev && exp_cnt != 16'hFFFF) exp_cnt++;
      prev_ev = ev;
      repeat (popn) void'(stq.pop_front());
      if (LAT == 0) begin
         arrive = exp_re;
         word   = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
      end else begin
         arrive = inflight_m && !fl;
         word   = pend;
      end
      if (fl) stq.delete();
      else if (arrive) begin
         stq.push_back(word[15:0]);
         stq.push_back(word[31:16]);
      end
      if (exp_re) pend = fifo_q.pop_front();
      inflight_m = (LAT == 1) && exp_re;
      #1;
   endtask

   logic [31:0] rd;
   logic        emp;
   logic [15:0] exp_first;
   int          pops;
   int          gaps;
   bit          started;

   initial begin
      rstn             = 1'b0;
      bus.flush_i      = 1'b0;
      bus.re_i         = 1'b0;
      bus.rsize_i      = RSIZE_16;
      bus.fifo_empty_i = 1'b0;
      bus.fifo_rdata_i = 32'hDEAD_BEEF;
      pend             = '0;
      model_reset();

      // Reset state, with a non-empty FIFO presented
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty_o", {31'd0, bus.empty_o}, 32'd1);
      chk("rst_fifo_re_o", {31'd0, bus.fifo_re_o}, 32'd0);
      chk("rst_rdata_o", bus.rdata_o, 32'h0);
      rstn = 1'b1;

      // Underruns: five reads while empty, then a flush must not clear the count
      repeat (5) step(1'b1, 1'b0, 1'b0, rd, emp);
      step(1'b0, 1'b0, 1'b1, rd, emp);
      step(1'b0, 1'b0, 1'b0, rd, emp);
`ifdef VIDEO_FIFO_ADAPTER_STATS_EN
      chk("underrun_cnt_after_flush", {16'd0, underrun_cnt}, 32'd5);
`endif

      // Four 16-bit reads across two words
      fifo_q.push_back(32'hAAAA_5555);
      fifo_q.push_back(32'hCCCC_3333);
      repeat (3) step(1'b0, 1'b0, 1'b0, rd, emp);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("rd16_0", rd, 32'h0000_5555);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("rd16_1", rd, 32'h0000_AAAA);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("rd16_2", rd, 32'h0000_3333);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("rd16_3", rd, 32'h0000_CCCC);
      step(1'b0, 1'b0, 1'b0, rd, emp); chk("drained_empty", {31'd0, emp}, 32'd1);

      // Misaligned 32-bit read straddling two FIFO words
      fifo_q.push_back(32'hAAAA_5555);
      fifo_q.push_back(32'hCCCC_3333);
      repeat (3) step(1'b0, 1'b0, 1'b0, rd, emp);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("mis_rd16", rd, 32'h0000_5555);
      step(1'b1, 1'b1, 1'b0, rd, emp); chk("mis_rd32", rd, 32'h3333_AAAA);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("mis_rd16_tail", rd, 32'h0000_CCCC);

      // Continuous 16-bit reads over 8 words: no bubble once data first appears
      for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
      pops = 0; gaps = 0; started = 1'b0;
      for (int i = 0; i < 40 && pops < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, rd, emp);
         if (!emp) begin started = 1'b1; pops++; end
         else if (started) gaps++;
      end
      chk("stream_pops", pops, 32'd16);
      chk("stream_gaps", gaps, 32'd0);

      // Flush with count=3 in the cycle a FIFO read would fire
      for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
      repeat (3) step(1'b0, 1'b0, 1'b0, rd, emp);
      step(1'b1, 1'b0, 1'b0, rd, emp);
      chk("pre_flush_count", stq.size(), 32'd3);
      step(1'b1, 1'b0, 1'b1, rd, emp);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("post_flush_empty", {31'd0, emp}, 32'd1);
      step(1'b0, 1'b0, 1'b0, rd, emp); chk("post_flush_empty2", {31'd0, emp}, 32'd1);
      repeat (4) step(1'b1, 1'b1, 1'b0, rd, emp);

      // Asynchronous reset mid-stream with a read in flight
      fifo_q.delete();
      stq.delete();
      step(1'b0, 1'b0, 1'b1, rd, emp);
      repeat (2) step(1'b0, 1'b0, 1'b0, rd, emp);
      for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
      repeat (2) step(1'b0, 1'b0, 1'b0, rd, emp);
      rstn = 1'b0;
      #1;
      chk("mid_rst_empty_o", {31'd0, bus.empty_o}, 32'd1);
      chk("mid_rst_fifo_re_o", {31'd0, bus.fifo_re_o}, 32'd0);
      chk("mid_rst_rdata_o", bus.rdata_o, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      exp_first = fifo_q[0][15:0];
      repeat (3) step(1'b0, 1'b0, 1'b0, rd, emp);
      step(1'b1, 1'b0, 1'b0, rd, emp); chk("post_rst_first", rd, {16'h0000, exp_first});

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() < 6 && $urandom_range(2) == 0) fifo_q.push_back($urandom);
         step($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(24) == 0, rd, emp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
